board_status_led_ctrl: RTL and testbench

Board status/LED stage that consumes the PCIe reset, CPU reset, software PIO LED bits and both DDR4 EMIF calibration status pairs, and drives the 9 board LEDs. It synchronizes the EMIF status flags, tracks each channel's calibration through a per-channel state machine with a timeout, stretches reset events into visible LED pulses, and produces a heartbeat. It sits directly downstream of the PCIe/DDR4 top-level and replaces its ad-hoc LED counters.

---
 rtl/board_status_led_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_board_status_led_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_status_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : board_status_led_ctrl
// Brief   : Board LED stage: EMIF calibration tracking, reset-pulse stretching,
//           heartbeat. Optional calibration timeout: STATUS_LED_CAL_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module board_status_led_ctrl #(
  parameter int HOLD_CYCLES = 33554432,
  parameter int BLINK_LOG2  = 25,
  parameter int CAL_TIMEOUT = 268435456
) (
  input  logic       clk_u59,
  input  logic       any_rst,
  input  logic       pcie_perstn,
  input  logic       cpu_reset,
  input  logic [3:0] pio_led,
  input  logic       cal_success_a,
  input  logic       cal_fail_a,
  input  logic       cal_success_b,
  input  logic       cal_fail_b,
  output logic [8:0] leds,
  output logic [1:0] cal_state_a,
  output logic [1:0] cal_state_b
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } cal_state_t;

  localparam int            HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam int            BW       = BLINK_LOG2 + 1;

`ifdef STATUS_LED_CAL_TIMEOUT_EN
  localparam int            TW       = $clog2(CAL_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CAL_TIMEOUT - 1);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^CAL_TIMEOUT;
`endif

  // Channel index 0 is EMIF A, index 1 is EMIF B.
  logic [1:0] succ_meta;
  logic [1:0] fail_meta;
  logic [1:0] s_succ;
  logic [1:0] s_fail;

  always_ff @(posedge clk_u59) begin
    if (any_rst) begin
      succ_meta <= '0;
      fail_meta <= '0;
      s_succ    <= '0;
      s_fail    <= '0;
    end else begin
      succ_meta <= {cal_success_b, cal_success_a};
      fail_meta <= {cal_fail_b, cal_fail_a};
      s_succ    <= succ_meta;
      s_fail    <= fail_meta;
    end
  end

  logic [BW-1:0] blk;

  always_ff @(posedge clk_u59) begin
    if (any_rst) begin
      blk <= '0;
    end else begin
      blk <= blk + 1'b1;
    end
  end

  logic [3:0] state_bus;
  logic [1:0] err_set;
  logic [1:0] ind;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    cal_state_t state;
    logic       tmo_hit;
    logic       ind_c;

`ifdef STATUS_LED_CAL_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_u59) begin
      if (any_rst) begin
        state   <= ST_WAIT;
`ifdef STATUS_LED_CAL_TIMEOUT_EN
        tmo_cnt <= '0;
`endif
      end else begin
        case (state)
          ST_WAIT: begin
`ifdef STATUS_LED_CAL_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
            if (s_fail[ch]) begin
              state <= ST_FAIL;
            end else if (s_succ[ch]) begin
              state <= ST_PASS;
`ifdef STATUS_LED_CAL_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else if (tmo_hit) begin
              state <= ST_TMO;
            end
          end
          ST_PASS: begin
`ifdef STATUS_LED_CAL_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            if (s_fail[ch]) begin
              state <= ST_FAIL;
            end else if (!s_succ[ch]) begin
              state <= ST_WAIT;
            end
          end
          ST_TMO: begin
            if (s_fail[ch]) begin
              state <= ST_FAIL;
            end else if (s_succ[ch]) begin
              state <= ST_PASS;
`ifdef STATUS_LED_CAL_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
          default: begin
            state <= ST_FAIL;
          end
        endcase
      end
    end

    // Mirrors the FAIL/TMO entry conditions so err rises on the same edge.
    assign err_set[ch] = ((state != ST_FAIL) && s_fail[ch]) ||
                         ((state == ST_WAIT) && !s_succ[ch] && tmo_hit);

    always_comb begin
      ind_c = 1'b0;
      case (state)
        ST_PASS: ind_c = 1'b1;
        ST_WAIT: ind_c = blk[BLINK_LOG2];
        ST_FAIL: ind_c = blk[BLINK_LOG2-3];
        default: ind_c = 1'b0;
      endcase
    end

    assign ind[ch]             = ind_c;
    assign state_bus[2*ch +: 2] = state;
  end

  assign cal_state_a = state_bus[1:0];
  assign cal_state_b = state_bus[3:2];

  logic err;

  always_ff @(posedge clk_u59) begin
    if (any_rst) begin
      err <= 1'b0;
    end else if (|err_set) begin
      err <= 1'b1;
    end
  end

  // Stretch slots: 0 = POR, 1 = CPU reset, 2 = PCIe PERST#.
  logic [HW-1:0] str_cnt [3];
  logic [2:0]    str_clr;
  logic [2:0]    str_act;

  assign str_clr = {~pcie_perstn, cpu_reset, 1'b0};

  always_ff @(posedge clk_u59) begin
    if (any_rst) begin
      for (int i = 0; i < 3; i++) begin
        str_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (str_clr[i]) begin
          str_cnt[i] <= '0;
        end else if (str_cnt[i] < HOLD_MAX) begin
          str_cnt[i] <= str_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A clearing input lights its LED on the same edge it is sampled.
  always_comb begin
    str_act = '0;
    for (int i = 0; i < 3; i++) begin
      str_act[i] = str_clr[i] | (str_cnt[i] < HOLD_MAX);
    end
  end

  always_ff @(posedge clk_u59) begin
    if (any_rst) begin
      leds <= '0;
    end else begin
      leds <= {ind[0],
               ind[1],
               blk[BLINK_LOG2],
               err,
               1'b0,
               str_act[0] | pio_led[3],
               str_act[2] | pio_led[2],
               str_act[1] | pio_led[1],
               str_act[0] | pio_led[0]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_status_led_ctrl.sv
`default_nettype none
// Bench for board_status_led_ctrl: vector table, directed corner sequences and
// random stimulus against a cycle-indexed behavioural model.
module tb_board_status_led_ctrl;

  localparam int HOLD = 16;
  localparam int BL   = 4;
  localparam int CT   = 100;
  localparam int BLK_PERIOD = 1 << (BL + 1);
  localparam int HN = 8192;

  logic       clk_u59 = 1'b0;
  logic       any_rst = 1'b1;
  logic       pcie_perstn = 1'b1;
  logic       cpu_reset = 1'b0;
  logic [3:0] pio_led = 4'h0;
  logic       cal_success_a = 1'b0;
  logic       cal_fail_a = 1'b0;
  logic       cal_success_b = 1'b0;
  logic       cal_fail_b = 1'b0;
  logic [8:0] leds;
  logic [1:0] cal_state_a;
  logic [1:0] cal_state_b;

  board_status_led_ctrl #(
    .HOLD_CYCLES(HOLD),
    .BLINK_LOG2 (BL),
    .CAL_TIMEOUT(CT)
  ) dut (
    .clk_u59      (clk_u59),
    .any_rst      (any_rst),
    .pcie_perstn  (pcie_perstn),
    .cpu_reset    (cpu_reset),
    .pio_led      (pio_led),
    .cal_success_a(cal_success_a),
    .cal_fail_a   (cal_fail_a),
    .cal_success_b(cal_success_b),
    .cal_fail_b   (cal_fail_b),
    .leds         (leds),
    .cal_state_a  (cal_state_a),
    .cal_state_b  (cal_state_b)
  );

  always #5 clk_u59 = ~clk_u59;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: everything is expressed as a function of the edge index since reset.
  int         m_n;
  int         m_state [2];
  int         m_wait_start [2];
  bit         m_err;
  int         m_last_cpu;
  int         m_last_pst;
  logic [8:0] m_leds;
  bit         h_s [2][HN];
  bit         h_f [2][HN];

  task automatic model_reset();
    m_n = 0;
    m_err = 1'b0;
    m_last_cpu = -1;
    m_last_pst = -1;
    m_leds = 9'h000;
    for (int ch = 0; ch < 2; ch++) begin
      m_state[ch] = 0;
      m_wait_start[ch] = 0;
    end
  endtask

  task automatic model_step();
    int blk;
    bit hb, fast, por, cpu_a, pst_a, s, f;
    bit ind [2];
    blk  = m_n % BLK_PERIOD;
    hb   = ((blk / (1 << BL)) % 2) == 1;
    fast = ((blk / (1 << (BL - 3))) % 2) == 1;
    for (int ch = 0; ch < 2; ch++) begin
      case (m_state[ch])
        0:       ind[ch] = hb;
        1:       ind[ch] = 1'b1;
        2:       ind[ch] = fast;
        default: ind[ch] = 1'b0;
      endcase
    end
    por   = m_n < HOLD;
    cpu_a = cpu_reset || ((m_n - m_last_cpu - 1) < HOLD);
    pst_a = !pcie_perstn || ((m_n - m_last_pst - 1) < HOLD);
    m_leds = {ind[0], ind[1], hb, m_err, 1'b0,
              por | pio_led[3], pst_a | pio_led[2], cpu_a | pio_led[1], por | pio_led[0]};
    for (int ch = 0; ch < 2; ch++) begin
      s = (m_n >= 2) ? h_s[ch][(m_n - 2) % HN] : 1'b0;
      f = (m_n >= 2) ? h_f[ch][(m_n - 2) % HN] : 1'b0;
      case (m_state[ch])
        0: begin
          if (f) begin
            m_state[ch] = 2;
            m_err = 1'b1;
          end else if (s) m_state[ch] = 1;
`ifdef STATUS_LED_CAL_TIMEOUT_EN
          else if (m_n - m_wait_start[ch] == CT - 1) begin
            m_state[ch] = 3;
            m_err = 1'b1;
          end
`endif
        end
        1: begin
          if (f) begin
            m_state[ch] = 2;
            m_err = 1'b1;
          end else if (!s) begin
            m_state[ch] = 0;
            m_wait_start[ch] = m_n + 1;
          end
        end
        3: begin
          if (f) m_state[ch] = 2;
          else if (s) m_state[ch] = 1;
        end
        default: ;
      endcase
    end
    h_s[0][m_n % HN] = cal_success_a;
    h_f[0][m_n % HN] = cal_fail_a;
    h_s[1][m_n % HN] = cal_success_b;
    h_f[1][m_n % HN] = cal_fail_b;
    if (cpu_reset) m_last_cpu = m_n;
    if (!pcie_perstn) m_last_pst = m_n;
    m_n++;
  endtask

  task automatic tick();
    if (any_rst) model_reset();
    else model_step();
    @(posedge clk_u59);
    #1;
    check("leds", leds, m_leds);
    check("cal_state_a", cal_state_a, m_state[0]);
    check("cal_state_b", cal_state_b, m_state[1]);
  endtask

  task automatic set_idle();
    any_rst = 1'b0;
    cpu_reset = 1'b0;
    pcie_perstn = 1'b1;
    pio_led = 4'h0;
    cal_success_a = 1'b0;
    cal_fail_a = 1'b0;
    cal_success_b = 1'b0;
    cal_fail_b = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    any_rst = 1'b1;
    tick();
    tick();
    any_rst = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         cpu;
    bit         perstn;
    logic [3:0] pio;
    int         cycles;
    logic [8:0] leds;
  } vec_t;

  vec_t tbl [8];
  int   ones;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 4'hF, 2,  9'h000};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 4'h0, 16, 9'h00F};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 4'h0, 16, 9'h1C0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'hA, 4,  9'h00A};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 4'h0, 1,  9'h002};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'h0, 11, 9'h002};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 4'h0, 5,  9'h1C2};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 4'h0, 1,  9'h1C0};

    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < tbl[v].cycles; c++) begin
        set_idle();
        any_rst = tbl[v].rst;
        cpu_reset = tbl[v].cpu;
        pcie_perstn = tbl[v].perstn;
        pio_led = tbl[v].pio;
        tick();
        check("tbl_leds", leds, tbl[v].leds);
        check("tbl_state_a", cal_state_a, 2'd0);
        check("tbl_state_b", cal_state_b, 2'd0);
      end
    end

    // Channel A pass latency, recalibration and WAIT blink.
    do_reset();
    repeat (10) tick();
    cal_success_a = 1'b1;
    tick();
    tick();
    check("a_pass_early", cal_state_a, 2'd0);
    tick();
    check("a_pass_latency", cal_state_a, 2'd1);
    tick();
    check("a_pass_led", leds[8], 1'b1);
    cal_success_a = 1'b0;
    tick();
    tick();
    check("a_recal_early", cal_state_a, 2'd1);
    tick();
    check("a_recal_wait", cal_state_a, 2'd0);
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      ones += int'(leds[8]);
    end
    check("a_wait_blink_duty", ones, 16);

    // Channel B fail and success together: fail wins, err sticks.
    do_reset();
    repeat (5) tick();
    cal_fail_b = 1'b1;
    cal_success_b = 1'b1;
    tick();
    tick();
    tick();
    check("b_fail_state", cal_state_b, 2'd2);
    tick();
    check("b_err_led", leds[5], 1'b1);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ones += int'(leds[7]);
    end
    check("b_fast_blink_duty", ones, 4);
    cal_fail_b = 1'b0;
    cal_success_b = 1'b0;
    repeat (10) tick();
    check("b_fail_sticky", cal_state_b, 2'd2);
    check("b_err_sticky", leds[5], 1'b1);

    // Calibration timeout.
    do_reset();
    repeat (99) tick();
    check("pre_tmo_state", cal_state_a, 2'd0);
    tick();
`ifdef STATUS_LED_CAL_TIMEOUT_EN
    check("tmo_state", cal_state_a, 2'd3);
    tick();
    check("tmo_led", leds[8], 1'b0);
    check("tmo_err", leds[5], 1'b1);
    cal_success_a = 1'b1;
    repeat (3) tick();
    check("tmo_late_pass", cal_state_a, 2'd1);
`else
    check("no_tmo_state", cal_state_a, 2'd0);
    repeat (50) tick();
    check("no_tmo_state_late", cal_state_a, 2'd0);
    check("no_tmo_err", leds[5], 1'b0);
`endif

    // PERST# pulse stretching, single and retriggered.
    do_reset();
    repeat (20) tick();
    pcie_perstn = 1'b0;
    tick();
    check("perst_led_latency", leds[2], 1'b1);
    pcie_perstn = 1'b1;
    repeat (15) tick();
    tick();
    check("perst_last_on", leds[2], 1'b1);
    tick();
    check("perst_off", leds[2], 1'b0);
    pcie_perstn = 1'b0;
    tick();
    pcie_perstn = 1'b1;
    repeat (7) tick();
    pcie_perstn = 1'b0;
    tick();
    pcie_perstn = 1'b1;
    repeat (15) tick();
    tick();
    check("perst_retrig_on", leds[2], 1'b1);
    tick();
    check("perst_retrig_off", leds[2], 1'b0);

    // Reset in the middle of operation.
    do_reset();
    cal_success_a = 1'b1;
    cal_fail_b = 1'b1;
    repeat (6) tick();
    check("mid_pass", cal_state_a, 2'd1);
    check("mid_err", leds[5], 1'b1);
    any_rst = 1'b1;
    tick();
    check("mid_rst_state", cal_state_a, 2'd0);
    check("mid_rst_leds", leds, 9'h000);
    any_rst = 1'b0;
    tick();
    check("mid_rst_err_clr", leds[5], 1'b0);
    check("mid_rst_por", leds[0], 1'b1);

    // Random stimulus against the model.
    set_idle();
    for (int i = 0; i < 3000; i++) begin
      any_rst = ($urandom_range(0, 299) == 0);
      cpu_reset = ($urandom_range(0, 39) == 0);
      pcie_perstn = ($urandom_range(0, 39) != 0);
      pio_led = 4'($urandom);
      if ($urandom_range(0, 29) == 0) cal_success_a = ~cal_success_a;
      if ($urandom_range(0, 29) == 0) cal_success_b = ~cal_success_b;
      if ($urandom_range(0, 149) == 0) cal_fail_a = ~cal_fail_a;
      if ($urandom_range(0, 149) == 0) cal_fail_b = ~cal_fail_b;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
